// File: rtl/game_pkg.sv
// game_pkg: shared FSM states, game_state encodings
// and default frame timing for the game controller.
package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAYING,
    S_DYING,
    S_OVER,
    S_WIN
  } state_t;

  localparam logic [1:0] GS_IDLE    = 2'd0;
  localparam logic [1:0] GS_PLAYING = 2'd1;
  localparam logic [1:0] GS_DYING   = 2'd2;
  localparam logic [1:0] GS_OVER    = 2'd3;

  localparam int DEATH_FRAMES_DEF = 120;
  localparam int FLASH_FRAMES_DEF = 8;

  // WIN shares the OVER code; win_flag tells them apart
  function automatic logic [1:0] gs_enc(input state_t s);
    case (s)
      S_PLAYING:    return GS_PLAYING;
      S_DYING:      return GS_DYING;
      S_OVER, S_WIN: return GS_OVER;
      default:      return GS_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/rise_detect.sv
// rise_detect: one-Clk pulse on each rising edge
// of a signal already in the Clk domain.
module rise_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic i_d,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge Clk) begin
    if (Reset) r_prev <= 1'b0;
    else       r_prev <= i_d;
  end

  assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/game_state_ctrl.sv
// game_state_ctrl: top-level game flow FSM with
// death timer, sprite flash and level restart.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int DEATH_FRAMES = DEATH_FRAMES_DEF,
  parameter int FLASH_FRAMES = FLASH_FRAMES_DEF
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       player1_dead,
  input  logic       player2_dead,
  input  logic       player1_at_door,
  input  logic       player2_at_door,
  input  logic       start_key,
  output logic [1:0] game_state,
  output logic       win_flag,
  output logic       level_reset,
  output logic       freeze_players,
  output logic [1:0] dead_who,
  output logic       dead_flash
);

  localparam int CW = $clog2(DEATH_FRAMES + 1);
  localparam int FW = $clog2(FLASH_FRAMES + 1);

  logic          r_fc_s1, r_fc_s2;
  logic          w_frame_tick, w_start_pulse;
  logic          w_dead, w_win;
  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [FW-1:0] r_fcnt, w_fcnt_nx;
  logic          r_flash, w_flash_nx;
  logic [1:0]    r_who, w_who_nx;
  logic          r_lr, w_lr_nx;
  logic [1:0]    r_gs;
  logic          r_win, r_freeze;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_fc_s1 <= 1'b0;
      r_fc_s2 <= 1'b0;
    end else begin
      r_fc_s1 <= frame_clk;
      r_fc_s2 <= r_fc_s1;
    end
  end

  rise_detect u_frame_rd (
    .Clk    (Clk),
    .Reset  (Reset),
    .i_d    (r_fc_s2),
    .o_rise (w_frame_tick)
  );

  rise_detect u_start_rd (
    .Clk    (Clk),
    .Reset  (Reset),
    .i_d    (start_key),
    .o_rise (w_start_pulse)
  );

  // hazard latches are still clearing while level_reset is out
  assign w_dead = (player1_dead | player2_dead) & ~r_lr;
  assign w_win  = player1_at_door & player2_at_door;

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_fcnt_nx  = r_fcnt;
    w_flash_nx = 1'b0;
    w_who_nx   = r_who;
    w_lr_nx    = 1'b0;
    unique case (r_state)
      S_IDLE, S_OVER, S_WIN: begin
        if (w_start_pulse) begin
          w_state_nx = S_PLAYING;
          w_lr_nx    = 1'b1;
          w_who_nx   = 2'b00;
        end
      end
      S_PLAYING: begin
        if (w_dead) begin
          w_state_nx = S_DYING;
          w_who_nx   = {player2_dead, player1_dead};
          w_cnt_nx   = '0;
          w_fcnt_nx  = '0;
          w_flash_nx = 1'b1;
        end else if (w_win) begin
          w_state_nx = S_WIN;
        end
      end
      S_DYING: begin
        w_flash_nx = r_flash;
        if (w_frame_tick) begin
          if (r_cnt == CW'(DEATH_FRAMES - 1)) begin
            w_state_nx = S_OVER;
            w_flash_nx = 1'b0;
          end else begin
            w_cnt_nx = r_cnt + CW'(1);
            if (r_fcnt == FW'(FLASH_FRAMES - 1)) begin
              w_fcnt_nx  = '0;
              w_flash_nx = ~r_flash;
            end else begin
              w_fcnt_nx = r_fcnt + FW'(1);
            end
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_fcnt   <= '0;
      r_flash  <= 1'b0;
      r_who    <= 2'b00;
      r_lr     <= 1'b0;
      r_gs     <= GS_IDLE;
      r_win    <= 1'b0;
      r_freeze <= 1'b1;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_fcnt   <= w_fcnt_nx;
      r_flash  <= w_flash_nx;
      r_who    <= w_who_nx;
      r_lr     <= w_lr_nx;
      r_gs     <= gs_enc(w_state_nx);
      r_win    <= (w_state_nx == S_WIN);
      r_freeze <= (w_state_nx != S_PLAYING);
    end
  end

  assign game_state     = r_gs;
  assign win_flag       = r_win;
  assign level_reset    = r_lr;
  assign freeze_players = r_freeze;
  assign dead_who       = r_who;
  assign dead_flash     = r_flash;

endmodule

// File: tb/tb_game_state_ctrl.sv
// tb_game_state_ctrl: vector table plus directed
// frame sequences, scored through an expectation queue.
module tb_game_state_ctrl;

  typedef struct {
    string      nm;
    logic       rst, sk, d1, d2, a1, a2;
    logic [1:0] gs;
    logic       win, lr, frz;
    logic [1:0] who;
    logic       fl;
  } vec_t;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic       player1_dead = 1'b0;
  logic       player2_dead = 1'b0;
  logic       player1_at_door = 1'b0;
  logic       player2_at_door = 1'b0;
  logic       start_key = 1'b0;
  logic [1:0] game_state;
  logic       win_flag;
  logic       level_reset;
  logic       freeze_players;
  logic [1:0] dead_who;
  logic       dead_flash;

  int   checks = 0;
  int   failures = 0;
  vec_t sb[$];
  vec_t tbl[10];

  always #5 Clk = ~Clk;

  game_state_ctrl dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .frame_clk       (frame_clk),
    .player1_dead    (player1_dead),
    .player2_dead    (player2_dead),
    .player1_at_door (player1_at_door),
    .player2_at_door (player2_at_door),
    .start_key       (start_key),
    .game_state      (game_state),
    .win_flag        (win_flag),
    .level_reset     (level_reset),
    .freeze_players  (freeze_players),
    .dead_who        (dead_who),
    .dead_flash      (dead_flash)
  );

  function automatic vec_t mk(
    input string nm,
    input logic rst, sk, d1, d2, a1, a2,
    input logic [1:0] gs,
    input logic win, lr, frz,
    input logic [1:0] who,
    input logic fl
  );
    vec_t v;
    v.nm = nm; v.rst = rst; v.sk = sk;
    v.d1 = d1; v.d2 = d2; v.a1 = a1; v.a2 = a2;
    v.gs = gs; v.win = win; v.lr = lr; v.frz = frz;
    v.who = who; v.fl = fl;
    return v;
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk();
    vec_t e;
    e = sb.pop_front();
    checks++;
    if ({game_state, win_flag, level_reset, freeze_players,
         dead_who, dead_flash} !==
        {e.gs, e.win, e.lr, e.frz, e.who, e.fl}) begin
      failures++;
      $display("FAIL %s: got gs=%0d win=%0b lr=%0b frz=%0b who=%b fl=%0b want gs=%0d win=%0b lr=%0b frz=%0b who=%b fl=%0b",
               e.nm, game_state, win_flag, level_reset,
               freeze_players, dead_who, dead_flash,
               e.gs, e.win, e.lr, e.frz, e.who, e.fl);
    end
  endtask

  task automatic apply(input vec_t v);
    Reset           = v.rst;
    start_key       = v.sk;
    player1_dead    = v.d1;
    player2_dead    = v.d2;
    player1_at_door = v.a1;
    player2_at_door = v.a2;
    sb.push_back(v);
    step();
    chk();
  endtask

  // one frame_clk period spans four Clk cycles
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_clk = 1'b1;
      step();
      step();
      frame_clk = 1'b0;
      step();
      step();
    end
  endtask

  initial begin
    //              nm           rst sk d1 d2 a1 a2  gs win lr frz who fl
    tbl[0] = mk("rst0",       1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0);
    tbl[1] = mk("rst1",       1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0);
    tbl[2] = mk("idle",       0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0);
    tbl[3] = mk("idle_dead",  0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0);
    tbl[4] = mk("start",      0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 0);
    tbl[5] = mk("start_hold", 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0);
    tbl[6] = mk("start_rel",  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0);
    tbl[7] = mk("one_door",   0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 2'b00, 0);
    tbl[8] = mk("p2_dead",    0, 0, 0, 1, 0, 0, 2, 0, 0, 1, 2'b10, 1);
    tbl[9] = mk("dying_hold", 0, 0, 0, 1, 0, 0, 2, 0, 0, 1, 2'b10, 1);

    // reset, start key held, first death
    for (int i = 0; i < 10; i++) begin
      if (i == 6) begin
        for (int k = 0; k < 8; k++)
          apply(mk("key_held", 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0));
      end
      apply(tbl[i]);
    end

    // death timer and flash; start ignored while dying
    frames(7);
    apply(mk("fl_f7",    0, 0, 0, 1, 0, 0, 2, 0, 0, 1, 2'b10, 1));
    frames(1);
    apply(mk("fl_f8",    0, 0, 0, 1, 0, 0, 2, 0, 0, 1, 2'b10, 0));
    apply(mk("dy_start", 0, 1, 0, 1, 0, 0, 2, 0, 0, 1, 2'b10, 0));
    apply(mk("dy_rel",   0, 0, 0, 1, 0, 0, 2, 0, 0, 1, 2'b10, 0));
    frames(8);
    apply(mk("fl_f16",   0, 0, 0, 1, 0, 0, 2, 0, 0, 1, 2'b10, 1));
    frames(103);
    apply(mk("f119",     0, 0, 0, 1, 0, 0, 2, 0, 0, 1, 2'b10, 1));
    frames(1);
    apply(mk("over",     0, 0, 0, 1, 0, 0, 3, 0, 0, 1, 2'b10, 0));

    // restart from OVER with a stale death latch
    apply(mk("restart",  0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 2'b00, 0));
    apply(mk("mask",     0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 2'b00, 0));
    apply(mk("cleared",  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0));

    // death beats win in the same cycle
    apply(mk("prio",     0, 0, 1, 0, 1, 1, 2, 0, 0, 1, 2'b01, 1));
    apply(mk("prio_hold",0, 0, 1, 0, 0, 0, 2, 0, 0, 1, 2'b01, 1));

    // reset mid-dying
    frames(50);
    apply(mk("f50",      0, 0, 1, 0, 0, 0, 2, 0, 0, 1, 2'b01, 1));
    apply(mk("rst_dying",1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0));
    apply(mk("rst_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0));

    // win, then restart; the dead mask lasts one cycle only
    apply(mk("start2",   0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 0));
    apply(mk("play2",    0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0));
    apply(mk("win",      0, 0, 0, 0, 1, 1, 3, 1, 0, 1, 2'b00, 0));
    apply(mk("win_hold", 0, 0, 0, 0, 1, 1, 3, 1, 0, 1, 2'b00, 0));
    apply(mk("win_rst",  0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 2'b00, 0));
    apply(mk("mask2",    0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0));
    apply(mk("late_dead",0, 0, 1, 0, 0, 0, 2, 0, 0, 1, 2'b01, 1));
    apply(mk("late_hold",0, 0, 0, 0, 0, 0, 2, 0, 0, 1, 2'b01, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
